stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 159 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear control for a six-digit BCD stopwatch.
//   clk, rst_n          system clock, async active-low reset
//   btn_start, btn_lap  raw async pushbuttons (synchronized and debounced here)
//   tick                1/100 s strobe
//   live_digits         current BCD count {min1,min0,sec1,sec0,ss1,ss0}
//   cnt_enable          one-cycle count pulse to the ss0 counter
//   cnt_clear           one-cycle clear to all digit counters
//   disp_digits         lap snapshot in LAP, live count otherwise
//   state               IDLE=0 RUN=1 LAP=2 STOP=3
//   overflow            sticky, count reached 59:59.99

// Per-button synchronizer + debouncer producing a single press pulse on an
// accepted 0->1 change.
//   btn_i    raw button
//   press_o  one-cycle pulse, combinational from registered state
module stopwatch_db #(
  parameter int unsigned           DB_WIDTH        = 20,
  parameter logic [DB_WIDTH-1:0]   DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam logic [DB_WIDTH-1:0] DB_LAST = DEBOUNCE_CYCLES - 1'b1;

  logic                sync1_q, sync2_q, acc_q, blocked_q;
  logic [DB_WIDTH-1:0] cnt_q;
  logic                ref_lvl, differ, accept;

  // After reset the button is blocked: it must first be seen low for a full
  // debounce window, so a button held through reset release never fires.
  // While blocked the reference level is treated as 1 (acc_q is 0 then).
  assign ref_lvl = blocked_q | acc_q;
  assign differ  = (sync2_q != ref_lvl);
  assign accept  = differ && (cnt_q == DB_LAST);
  assign press_o = accept && sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      acc_q     <= 1'b0;
      blocked_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (!differ) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q     <= '0;
        acc_q     <= sync2_q;
        blocked_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int unsigned DB_WIDTH        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        tick,
  input  logic [23:0] live_digits,
  output logic        cnt_enable,
  output logic        cnt_clear,
  output logic [23:0] disp_digits,
  output logic [1:0]  state,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, STOP = 2'd3} state_e;

  localparam logic [23:0]         MAX_CNT = 24'h595999;
  localparam logic [DB_WIDTH-1:0] DB_CYC  = DB_WIDTH'(DEBOUNCE_CYCLES);

  state_e      state_q;
  logic        cnt_enable_q, cnt_clear_q, overflow_q;
  logic [23:0] lap_q;
  logic [1:0]  btn_raw, press;
  logic        start_p, lap_p, counting, at_max;

  assign btn_raw = {btn_lap, btn_start};

  stopwatch_db #(.DB_WIDTH(DB_WIDTH), .DEBOUNCE_CYCLES(DB_CYC)) u_db [1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_raw),
    .press_o (press)
  );

  assign start_p  = press[0];
  assign lap_p    = press[1];
  // Decision uses the pre-edge state, so a same-cycle transition does not
  // affect whether this tick counts.
  assign counting = tick && ((state_q == RUN) || (state_q == LAP));
  assign at_max   = (live_digits == MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_enable_q <= 1'b0;
      cnt_clear_q  <= 1'b0;
      overflow_q   <= 1'b0;
      lap_q        <= '0;
    end else begin
      cnt_enable_q <= counting && !at_max;
      cnt_clear_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_p) state_q <= RUN;
        RUN: begin
          // Saturate at 59:59.99 instead of wrapping; beats any button.
          if (counting && at_max) begin
            state_q    <= STOP;
            overflow_q <= 1'b1;
          end else if (start_p) begin
            state_q <= STOP;
          end else if (lap_p) begin
            state_q <= LAP;
            lap_q   <= live_digits;
          end
        end
        LAP: begin
          if (counting && at_max) begin
            state_q    <= STOP;
            overflow_q <= 1'b1;
          end else if (start_p) begin
            state_q <= STOP;
          end else if (lap_p) begin
            state_q <= RUN;
          end
        end
        STOP: begin
          // start wins a tie even when overflow makes it a no-op.
          if (start_p) begin
            if (!overflow_q) state_q <= RUN;
          end else if (lap_p) begin
            state_q     <= IDLE;
            cnt_clear_q <= 1'b1;
            overflow_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_enable  = cnt_enable_q;
  assign cnt_clear   = cnt_clear_q;
  assign overflow    = overflow_q;
  assign state       = state_q;
  assign disp_digits = (state_q == LAP) ? lap_q : live_digits;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0, btn_lap = 1'b0, tick = 1'b0;
  logic [23:0] live_digits = 24'h0;
  logic        cnt_enable, cnt_clear, overflow;
  logic [23:0] disp_digits;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(20'd4), .DB_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_lap(btn_lap),
    .tick(tick), .live_digits(live_digits), .cnt_enable(cnt_enable),
    .cnt_clear(cnt_clear), .disp_digits(disp_digits), .state(state),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic push(string tag, logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_chk(logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] v);
    push(tag, v);
    pop_chk(obs);
  endtask

  // Advance n clocks, land 1 time unit after the last rising edge.
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(bit s, bit l, int hold);
    btn_start = s;
    btn_lap   = l;
    cyc(hold);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    cyc(10);
  endtask

  task automatic tick_pulse(logic exp_en, string tag);
    tick = 1'b1;
    push(tag, 32'(exp_en));
    cyc(1);
    tick = 1'b0;
    pop_chk(32'(cnt_enable));
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(cnt_enable), 32'd0);
    chk("rst_clr", 32'(cnt_clear), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);

    // Short glitch rejected
    press(1'b1, 1'b0, 2);
    chk("glitch_state", 32'(state), 32'd0);

    // Tick while idle does nothing
    tick_pulse(1'b0, "idle_tick");

    // Start press -> RUN
    press(1'b1, 1'b0, 10);
    chk("start_run", 32'(state), 32'd1);
    chk("en_quiet", 32'(cnt_enable), 32'd0);

    live_digits = 24'h000100;
    tick_pulse(1'b1, "run_tick1");
    cyc(1);
    chk("en_one_cycle", 32'(cnt_enable), 32'd0);
    live_digits = 24'h010959;
    tick_pulse(1'b1, "run_tick2");
    live_digits = 24'h595998;
    tick_pulse(1'b1, "run_tick3");
    cyc(1);

    // Lap freeze
    live_digits = 24'h012345;
    press(1'b0, 1'b1, 10);
    chk("lap_state", 32'(state), 32'd2);
    chk("lap_disp", 32'(disp_digits), 32'h012345);
    live_digits = 24'h012400;
    cyc(1);
    chk("lap_frozen", 32'(disp_digits), 32'h012345);
    tick_pulse(1'b1, "lap_tick");
    press(1'b0, 1'b1, 10);
    chk("lap_release", 32'(state), 32'd1);
    chk("disp_live", 32'(disp_digits), 32'h012400);

    // Both buttons together: start wins
    live_digits = 24'h020000;
    press(1'b1, 1'b1, 10);
    chk("both_state", 32'(state), 32'd3);
    chk("both_disp", 32'(disp_digits), 32'h020000);
    tick_pulse(1'b0, "stop_tick");

    // Overflow
    press(1'b1, 1'b0, 10);
    chk("resume_run", 32'(state), 32'd1);
    live_digits = 24'h595999;
    tick_pulse(1'b0, "ovf_no_en");
    chk("ovf_state", 32'(state), 32'd3);
    chk("ovf_flag", 32'(overflow), 32'd1);
    press(1'b1, 1'b0, 10);
    chk("ovf_start_ignored", 32'(state), 32'd3);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    btn_lap = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (state == 2'd0) break;
    end
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_pulse", 32'(cnt_clear), 32'd1);
    chk("clear_ovf", 32'(overflow), 32'd0);
    cyc(1);
    chk("clear_one_cycle", 32'(cnt_clear), 32'd0);
    btn_lap = 1'b0;
    cyc(10);
    live_digits = 24'h0;

    // Reset in LAP with start held
    press(1'b1, 1'b0, 10);
    chk("run_again", 32'(state), 32'd1);
    live_digits = 24'h000500;
    press(1'b0, 1'b1, 10);
    chk("lap_again", 32'(state), 32'd2);
    live_digits = 24'h000600;
    btn_start = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_disp", 32'(disp_digits), 32'h000600);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_en", 32'(cnt_enable), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("held_no_press", 32'(state), 32'd0);
    btn_start = 1'b0;
    cyc(10);
    chk("release_no_press", 32'(state), 32'd0);
    press(1'b1, 1'b0, 10);
    chk("repress_run", 32'(state), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
